rst_sequencer: RTL

System reset sequencer for the Minisys-1A SoC. Merges three reset sources into staged reset outputs: the synchronous board reset, the watchdog bite pulse and a keyed software-reset write from the CPU IO bus. Peripherals, including the watchdog, leave reset first and the CPU follows. A readable cause register records why the last reset happened and counts non-board resets.

---
 rtl/rst_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// Staged system reset sequencer: merges board reset, watchdog bite and a keyed
// software reset into periph_reset/cpu_reset, with a readable cause register.
// Optional feature macro: RST_SW_RESET_EN (software key write 16'h5A5A acts as a trigger).
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | both resets released, waiting for a trigger
// SEQ   | sequencing; cnt counts edges since the trigger edge
module rst_sequencer #(
    parameter int PERIPH_HOLD = 4,
    parameter int CPU_LAG     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wdt_bite,
    input  logic        cs,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        periph_reset,
    output logic        cpu_reset
);

    typedef enum logic {
        RUN = 1'b0,
        SEQ = 1'b1
    } state_t;

    localparam logic [7:0]  HOLD_END = 8'(PERIPH_HOLD);
    localparam logic [7:0]  SEQ_END  = 8'(PERIPH_HOLD + CPU_LAG);
    localparam logic [15:0] KEY_SW   = 16'h5A5A;
    localparam logic [15:0] KEY_CLR  = 16'hC1EA;

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic        wdt_q;
    logic        por;
    logic        wdt_seen;
    logic        sw_seen;
    logic [3:0]  count;
    logic        wdt_rise;
    logic        key_hit;
    logic        clear_hit;
    logic        event_hit;
    logic        start;

    always_comb begin
        wdt_rise  = wdt_bite & ~wdt_q;
        clear_hit = cs & we & (wdata == KEY_CLR);
`ifdef RST_SW_RESET_EN
        // Key writes only count in RUN; during SEQ they are dropped entirely.
        key_hit   = cs & we & (wdata == KEY_SW) & (state == RUN);
`else
        key_hit   = 1'b0;
`endif
        event_hit = wdt_rise | key_hit;
        start     = (state == RUN) & event_hit;
        cnt_inc   = cnt + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= SEQ;
            cnt          <= 8'd0;
            periph_reset <= 1'b1;
            cpu_reset    <= 1'b1;
            wdt_q        <= 1'b1;
            por          <= 1'b1;
            wdt_seen     <= 1'b0;
            sw_seen      <= 1'b0;
            count        <= 4'd0;
        end else begin
            wdt_q <= wdt_bite;

            case (state)
                RUN: begin
                    if (start) begin
                        state        <= SEQ;
                        cnt          <= 8'd0;
                        periph_reset <= 1'b1;
                        cpu_reset    <= 1'b1;
                    end
                end
                SEQ: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == HOLD_END)
                        periph_reset <= 1'b0;
                    if (cnt_inc == SEQ_END) begin
                        cpu_reset <= 1'b0;
                        state     <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            // Clear takes effect first, then this edge's events are recorded.
            por      <= por & ~clear_hit;
            wdt_seen <= (wdt_seen & ~clear_hit) | wdt_rise;
            sw_seen  <= (sw_seen & ~clear_hit) | key_hit;
            if (clear_hit)
                count <= event_hit ? 4'd1 : 4'd0;
            else if (event_hit && count != 4'hF)
                count <= count + 4'd1;
        end
    end

    assign rdata = {8'h00, count, 1'b0, sw_seen, wdt_seen, por};

endmodule
